// File: rtl/acc_adder_tree.sv
// Pipelined signed adder tree reducing NUM_IN operands per beat, followed by a
// frame accumulator with optional saturation and a sticky per-frame overflow flag.
module acc_adder_tree #(
   parameter int IN_W   = 18,
   parameter int NUM_IN = 4,
   parameter int ACC_W  = 24,
   parameter bit SAT_EN = 1'b1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   input  logic [NUM_IN*IN_W-1:0] in_data,
   input  logic                   in_last,
   output logic                   out_valid,
   output logic [ACC_W-1:0]       out_sum,
   output logic                   out_ovf
);

   localparam int L  = $clog2(NUM_IN);
   localparam int TW = IN_W + L;

   // Level s carries NUM_IN>>s operands of width IN_W+s; level 0 is the raw input.
   for (genvar s = 0; s <= L; s++) begin : g_lvl
      localparam int W = IN_W + s;
      localparam int N = NUM_IN >> s;
      logic [N*W-1:0] dat;
      logic           vld;
      logic           lst;

      if (s == 0) begin : g_in
         always_comb begin
            dat = in_data;
            vld = in_valid;
            lst = in_last & in_valid;
         end
      end else begin : g_add
         logic [N*W-1:0] dat_d;
         logic [W-2:0]   opa;
         logic [W-2:0]   opb;

         always_comb begin
            dat_d = '0;
            opa   = '0;
            opb   = '0;
            for (int k = 0; k < N; k++) begin
               opa = g_lvl[s-1].dat[(2*k)*(W-1)   +: W-1];
               opb = g_lvl[s-1].dat[(2*k+1)*(W-1) +: W-1];
               dat_d[k*W +: W] = {opa[W-2], opa} + {opb[W-2], opb};
            end
         end

         always_ff @(posedge clk) begin
            dat <= dat_d;
            if (rst) begin
               vld <= 1'b0;
               lst <= 1'b0;
            end else begin
               vld <= g_lvl[s-1].vld;
               lst <= g_lvl[s-1].lst;
            end
         end
      end
   end

   logic [TW-1:0]    tree_sum;
   logic             tree_vld;
   logic             tree_lst;
   logic [ACC_W:0]   ext_sum;
   logic [ACC_W:0]   base;
   logic [ACC_W:0]   nxt;
   logic             ovf;
   logic [ACC_W-1:0] res;

   logic [ACC_W-1:0] acc_q,    acc_d;
   logic             first_q,  first_d;
   logic             sticky_q, sticky_d;
   logic [ACC_W-1:0] sum_q,    sum_d;
   logic             ovf_q,    ovf_d;
   logic             vld_q,    vld_d;

   assign tree_sum = g_lvl[L].dat;
   assign tree_vld = g_lvl[L].vld;
   assign tree_lst = g_lvl[L].lst;

   always_comb begin
      ext_sum = {{(ACC_W+1-TW){tree_sum[TW-1]}}, tree_sum};
      base    = first_q ? '0 : {acc_q[ACC_W-1], acc_q};
      nxt     = base + ext_sum;
      // One guard bit is enough: both addends already fit in ACC_W bits.
      ovf     = nxt[ACC_W] ^ nxt[ACC_W-1];
      res     = nxt[ACC_W-1:0];
      if (SAT_EN && ovf) begin
         res = nxt[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end

      acc_d    = acc_q;
      first_d  = first_q;
      sticky_d = sticky_q;
      sum_d    = sum_q;
      ovf_d    = ovf_q;
      vld_d    = 1'b0;
      if (tree_vld) begin
         acc_d = res;
         if (tree_lst) begin
            first_d  = 1'b1;
            sticky_d = 1'b0;
            sum_d    = res;
            ovf_d    = sticky_q | ovf;
            vld_d    = 1'b1;
         end else begin
            first_d  = 1'b0;
            sticky_d = sticky_q | ovf;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q    <= '0;
         first_q  <= 1'b1;
         sticky_q <= 1'b0;
         sum_q    <= '0;
         ovf_q    <= 1'b0;
         vld_q    <= 1'b0;
      end else begin
         acc_q    <= acc_d;
         first_q  <= first_d;
         sticky_q <= sticky_d;
         sum_q    <= sum_d;
         ovf_q    <= ovf_d;
         vld_q    <= vld_d;
      end
   end

   assign out_valid = vld_q;
   assign out_sum   = sum_q;
   assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_acc_adder_tree.sv
// Drives three acc_adder_tree configurations with one shared stimulus stream and
// compares every cycle against a frame-level arithmetic model.
module tb_acc_adder_tree;

   localparam int IN_W   = 18;
   localparam int NUM_IN = 4;

   logic                   clk;
   logic                   rst;
   logic                   in_valid;
   logic [NUM_IN*IN_W-1:0] in_data;
   logic                   in_last;

   logic        v24, vs20, vw20;
   logic [23:0] s24;
   logic [19:0] ss20, sw20;
   logic        o24, os20, ow20;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   acc_adder_tree #(.IN_W(IN_W), .NUM_IN(NUM_IN), .ACC_W(24), .SAT_EN(1'b1)) u_dut24 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
      .out_valid(v24), .out_sum(s24), .out_ovf(o24));

   acc_adder_tree #(.IN_W(IN_W), .NUM_IN(NUM_IN), .ACC_W(20), .SAT_EN(1'b1)) u_sat20 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
      .out_valid(vs20), .out_sum(ss20), .out_ovf(os20));

   acc_adder_tree #(.IN_W(IN_W), .NUM_IN(NUM_IN), .ACC_W(20), .SAT_EN(1'b0)) u_wrap20 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
      .out_valid(vw20), .out_sum(sw20), .out_ovf(ow20));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic chk(input string tag, input logic signed [63:0] got,
                      input logic signed [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got %0d, expected %0d", tag, cyc, got, exp);
      end
   endtask

   // Model: one entry per completed frame, carrying all three configurations.
   typedef struct packed {
      int                  due;
      logic [2:0][63:0]    sum;
      logic [2:0]          ovf;
   } pend_t;

   pend_t  pq[$];
   longint m_acc[3];
   bit     m_first[3];
   bit     m_sticky[3];
   longint held_sum[3];
   bit     held_ovf[3];
   int     cfg_w[3]   = '{24, 20, 20};
   bit     cfg_sat[3] = '{1'b1, 1'b1, 1'b0};

   initial begin : mon
      pend_t  e;
      bit     exp_v;
      longint s, r, mx, mn, span;
      bit     o;
      for (int c = 0; c < 3; c++) begin
         m_acc[c] = 0; m_first[c] = 1'b1; m_sticky[c] = 1'b0;
         held_sum[c] = 0; held_ovf[c] = 1'b0;
      end
      forever begin
         @(negedge clk);
         if (cyc >= 1) begin
            exp_v = (pq.size() > 0) && (pq[0].due == cyc);
            if (exp_v) begin
               e = pq.pop_front();
               for (int c = 0; c < 3; c++) begin
                  held_sum[c] = longint'(e.sum[c]);
                  held_ovf[c] = e.ovf[c];
               end
            end
            chk("vld24",  {63'd0, v24},  {63'd0, exp_v});
            chk("sum24",  $signed(s24),  held_sum[0]);
            chk("ovf24",  {63'd0, o24},  {63'd0, held_ovf[0]});
            chk("vlds20", {63'd0, vs20}, {63'd0, exp_v});
            chk("sums20", $signed(ss20), held_sum[1]);
            chk("ovfs20", {63'd0, os20}, {63'd0, held_ovf[1]});
            chk("vldw20", {63'd0, vw20}, {63'd0, exp_v});
            chk("sumw20", $signed(sw20), held_sum[2]);
            chk("ovfw20", {63'd0, ow20}, {63'd0, held_ovf[2]});
         end
         // Inputs seen now are sampled at the next edge (cyc+1); result shows at cyc+3.
         if (rst) begin
            pq.delete();
            for (int c = 0; c < 3; c++) begin
               m_acc[c] = 0; m_first[c] = 1'b1; m_sticky[c] = 1'b0;
               held_sum[c] = 0; held_ovf[c] = 1'b0;
            end
         end else if (in_valid) begin
            s = 0;
            for (int k = 0; k < NUM_IN; k++)
               s += longint'($signed(in_data[k*IN_W +: IN_W]));
            e = '0;
            e.due = cyc + 3;
            for (int c = 0; c < 3; c++) begin
               mx   = (longint'(1) << (cfg_w[c]-1)) - 1;
               mn   = -(longint'(1) << (cfg_w[c]-1));
               span = longint'(1) << cfg_w[c];
               r = m_first[c] ? s : m_acc[c] + s;
               o = (r > mx) || (r < mn);
               if (o && cfg_sat[c]) r = (r > mx) ? mx : mn;
               while (r > mx) r -= span;
               while (r < mn) r += span;
               m_acc[c] = r;
               if (in_last) begin
                  e.sum[c]    = r;
                  e.ovf[c]    = m_sticky[c] | o;
                  m_first[c]  = 1'b1;
                  m_sticky[c] = 1'b0;
               end else begin
                  m_first[c]  = 1'b0;
                  m_sticky[c] = m_sticky[c] | o;
               end
            end
            if (in_last) pq.push_back(e);
         end
      end
   end

   task automatic drive(input bit v, input bit l, input int a, input int b,
                        input int c, input int d);
      @(posedge clk);
      #1;
      in_valid = v;
      in_last  = l;
      in_data  = {d[17:0], c[17:0], b[17:0], a[17:0]};
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         drive(1'b0, 1'($urandom), int'($urandom), int'($urandom),
               int'($urandom), int'($urandom));
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst      = 1'b1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   function automatic int rnd_op();
      if ($urandom_range(0, 3) == 0) return $urandom_range(0, 40) - 20;
      return int'($urandom_range(0, 262143)) - 131072;
   endfunction

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      drive(1, 1, 131071, 131071, -131072, 1);
      idle(5);
      chk("plan_single_sum", $signed(s24), 131071);
      chk("plan_single_ovf", {63'd0, o24}, 0);

      repeat (2) drive(1, 0, 100, 200, 300, 400);
      drive(1, 1, 100, 200, 300, 400);
      idle(5);
      chk("plan_3beat_sum", $signed(s24), 3000);

      drive(1, 0, 100, 200, 300, 400); idle(3);
      drive(1, 0, 100, 200, 300, 400); idle(3);
      drive(1, 1, 100, 200, 300, 400);
      idle(5);
      chk("plan_gap_sum", $signed(s24), 3000);

      drive(1, 1, 10, 0, 0, 0);
      drive(1, 1, -5, 0, 0, 0);
      idle(5);
      chk("plan_b2b_sum", $signed(s24), -5);

      drive(1, 0, 131071, 131071, 131071, 131071);
      drive(1, 1, 131071, 131071, 131071, 131071);
      idle(5);
      chk("plan_sat_sum",  $signed(ss20), 524287);
      chk("plan_sat_ovf",  {63'd0, os20}, 1);
      chk("plan_wrap_sum", $signed(sw20), -8);
      chk("plan_wrap_ovf", {63'd0, ow20}, 1);
      chk("plan_wide_sum", $signed(s24), 1048568);

      drive(1, 1, 1, 1, 1, 1);
      idle(5);
      chk("plan_wrap_next_sum", $signed(sw20), 4);
      chk("plan_wrap_next_ovf", {63'd0, ow20}, 0);

      drive(1, 0, 5000, 6000, 7000, 8000);
      drive(1, 0, 5000, 6000, 7000, 8000);
      do_reset();
      chk("plan_rst_sum", $signed(s24), 0);
      chk("plan_rst_vld", {63'd0, v24}, 0);
      drive(1, 1, 3, 4, 0, 0);
      idle(5);
      chk("plan_rst_frame_sum", $signed(s24), 7);
      chk("plan_rst_frame_ovf", {63'd0, o24}, 0);

      for (int f = 0; f < 400; f++) begin
         int nb;
         nb = $urandom_range(1, 4);
         for (int b = 0; b < nb; b++) begin
            drive(1, b == nb-1, rnd_op(), rnd_op(), rnd_op(), rnd_op());
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
         end
         if ($urandom_range(0, 39) == 0) do_reset();
      end
      idle(6);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
